// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the play detector: state encoding seen by the control
// unit and the hexa7seg debug display, plus the one-hot test used on jogada.
package detector_jogada_pkg;

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      DEB_PRESS   = 4'd1,
      PRESSED     = 4'd2,
      DEB_RELEASE = 4'd3
   } estado_t;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/detector_jogada_sincronizador.sv
// Per-bit two-flop synchroniser for asynchronous level inputs; async active-low reset.
module sincronizador_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/detector_jogada.sv
// Synchronises and debounces the button bus and emits one play strobe per press,
// holding the accepted key pattern on jogada until the next accepted press.
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] botoes,
   output logic       jogada_feita,
   output logic [3:0] jogada,
   output logic       jogada_valida,
   output logic [3:0] db_estado
);

   // DEBOUNCE_CYCLES must be at least 2 so the counter has a distinct terminal value.
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync;
   estado_t          state, state_next;
   logic [3:0]       candidate, candidate_next;
   logic [CNT_W-1:0] counter, counter_next;
   logic             load_jogada;

   sincronizador_2ff #(.WIDTH(4)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (botoes),
      .q     (sync)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         candidate <= 4'd0;
         counter   <= '0;
      end else begin
         state     <= state_next;
         candidate <= candidate_next;
         counter   <= counter_next;
      end
   end

   always_comb begin
      state_next     = state;
      candidate_next = candidate;
      counter_next   = counter;
      load_jogada    = 1'b0;
      case (state)
         IDLE: begin
            if (habilita && (sync != 4'd0)) begin
               candidate_next = sync;
               counter_next   = '0;
               state_next     = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (!habilita || (sync == 4'd0)) begin
               state_next = IDLE;
            end else if (sync != candidate) begin
               candidate_next = sync;
               counter_next   = '0;
            end else if (counter == CNT_LAST) begin
               load_jogada = 1'b1;
               state_next  = PRESSED;
            end else begin
               counter_next = counter + 1'b1;
            end
         end
         PRESSED: begin
            // Any non-zero change while held is the same physical press.
            if (sync == 4'd0) begin
               counter_next = '0;
               state_next   = DEB_RELEASE;
            end
         end
         DEB_RELEASE: begin
            if (sync != 4'd0) begin
               state_next = PRESSED;
            end else if (counter == CNT_LAST) begin
               state_next = IDLE;
            end else begin
               counter_next = counter + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // jogada_feita is a one-cycle strobe with no back-pressure: it rises in the
   // cycle jogada first holds a new press and the consumer must take it then.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jogada_feita  <= 1'b0;
         jogada        <= 4'd0;
         jogada_valida <= 1'b0;
      end else begin
         jogada_feita <= load_jogada;
         if (load_jogada) begin
            jogada        <= candidate;
            jogada_valida <= is_one_hot(candidate);
         end
      end
   end

   assign db_estado = state;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a short debounce window of 4 cycles.
module tb_detector_jogada;

   logic       clock;
   logic       reset;
   logic       habilita;
   logic [3:0] botoes;
   logic       jogada_feita;
   logic [3:0] jogada;
   logic       jogada_valida;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;

   detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .habilita      (habilita),
      .botoes        (botoes),
      .jogada_feita  (jogada_feita),
      .jogada        (jogada),
      .jogada_valida (jogada_valida),
      .db_estado     (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // one rising edge, then settle to the falling edge for sampling/driving
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      habilita = 1'b1;
      botoes   = 4'b0010;
      repeat (3) step();
      n_checks++; if (jogada_feita !== 1'b0) begin n_fail++; $display("FAIL reset_feita got=%b exp=0", jogada_feita); end
      n_checks++; if (jogada !== 4'd0) begin n_fail++; $display("FAIL reset_jogada got=%b exp=0000", jogada); end
      n_checks++; if (jogada_valida !== 1'b0) begin n_fail++; $display("FAIL reset_valida got=%b exp=0", jogada_valida); end
      n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
      botoes = 4'b0000;
      reset  = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         n_checks++; if (jogada_feita !== 1'b0 || db_estado !== 4'd0) begin
            n_fail++; $display("FAIL idle_after_reset edge=%0d feita=%b estado=%0d exp 0/0", e, jogada_feita, db_estado);
         end
      end
   endtask

   task automatic test_single_press();
      botoes = 4'b0100;
      for (int e = 1; e <= 10; e++) begin
         step();
         n_checks++; if (jogada_feita !== (e == 7)) begin
            n_fail++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", e, jogada_feita, (e == 7));
         end
         if (e == 3) begin
            n_checks++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL press_deb_state got=%0d exp=1", db_estado); end
         end
         if (e == 6) begin
            n_checks++; if (jogada !== 4'd0) begin n_fail++; $display("FAIL press_early_jogada got=%b exp=0000", jogada); end
         end
         if (e == 7) begin
            n_checks++; if (jogada !== 4'b0100) begin n_fail++; $display("FAIL press_jogada got=%b exp=0100", jogada); end
            n_checks++; if (jogada_valida !== 1'b1) begin n_fail++; $display("FAIL press_valida got=%b exp=1", jogada_valida); end
            n_checks++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL press_state got=%0d exp=2", db_estado); end
         end
      end
      botoes = 4'b0000;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (e == 6) begin
            n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL release_deb_state got=%0d exp=3", db_estado); end
         end
         if (e == 7) begin
            n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL release_idle got=%0d exp=0", db_estado); end
            n_checks++; if (jogada !== 4'b0100) begin n_fail++; $display("FAIL release_hold got=%b exp=0100", jogada); end
         end
      end
   endtask

   task automatic test_press_bounce();
      int pulses = 0;
      logic [3:0] pat [0:5];
      pat = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
      for (int e = 1; e <= 16; e++) begin
         botoes = (e <= 6) ? pat[e-1] : 4'b0001;
         step();
         if (jogada_feita === 1'b1) pulses++;
         if (e == 12) begin
            n_checks++; if (jogada !== 4'b0100) begin n_fail++; $display("FAIL bounce_old_jogada got=%b exp=0100", jogada); end
         end
         if (e == 13) begin
            n_checks++; if (jogada_feita !== 1'b1) begin n_fail++; $display("FAIL bounce_pulse_edge got=%b exp=1", jogada_feita); end
            n_checks++; if (jogada !== 4'b0001) begin n_fail++; $display("FAIL bounce_jogada got=%b exp=0001", jogada); end
         end
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses); end
      botoes = 4'b0000;
      repeat (10) step();
      n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL bounce_back_idle got=%0d exp=0", db_estado); end
   endtask

   task automatic test_release_bounce();
      int pulses = 0;
      logic [3:0] rel [0:4];
      rel = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
      botoes = 4'b1000;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (jogada_feita === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 1 || jogada !== 4'b1000) begin
         n_fail++; $display("FAIL hold_press pulses=%0d jogada=%b exp 1/1000", pulses, jogada);
      end
      pulses = 0;
      for (int e = 1; e <= 12; e++) begin
         botoes = (e <= 5) ? rel[e-1] : 4'b0000;
         step();
         if (jogada_feita === 1'b1) pulses++;
         if (e == 4) begin
            n_checks++; if (db_estado !== 4'd2) begin n_fail++; $display("FAIL rel_bounce_pressed got=%0d exp=2", db_estado); end
         end
         if (e == 10) begin
            n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL rel_still_deb got=%0d exp=3", db_estado); end
         end
         if (e == 11) begin
            n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL rel_idle got=%0d exp=0", db_estado); end
         end
      end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rel_second_pulse got=%0d exp=0", pulses); end
   endtask

   task automatic test_habilita();
      int pulses = 0;
      habilita = 1'b0;
      botoes   = 4'b0010;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (jogada_feita === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 0 || db_estado !== 4'd0) begin
         n_fail++; $display("FAIL hab_off pulses=%0d estado=%0d exp 0/0", pulses, db_estado);
      end
      botoes = 4'b0000;
      repeat (3) step();
      habilita = 1'b1;
      botoes   = 4'b0010;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (jogada_feita === 1'b1) pulses++;
         if (e == 4) begin
            n_checks++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL hab_drop_deb got=%0d exp=1", db_estado); end
            habilita = 1'b0;
         end
      end
      n_checks++; if (pulses != 0 || db_estado !== 4'd0 || jogada !== 4'b1000) begin
         n_fail++; $display("FAIL hab_drop pulses=%0d estado=%0d jogada=%b exp 0/0/1000", pulses, db_estado, jogada);
      end
      botoes   = 4'b0000;
      habilita = 1'b1;
      repeat (4) step();
   endtask

   task automatic test_multi_key_and_reset();
      int pulses = 0;
      botoes = 4'b0011;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (jogada_feita === 1'b1) pulses++;
         if (e == 7) begin
            n_checks++; if (jogada_feita !== 1'b1 || jogada !== 4'b0011) begin
               n_fail++; $display("FAIL multi_pulse feita=%b jogada=%b exp 1/0011", jogada_feita, jogada);
            end
            n_checks++; if (jogada_valida !== 1'b0) begin n_fail++; $display("FAIL multi_valida got=%b exp=0", jogada_valida); end
         end
      end
      botoes = 4'b0100;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (jogada_feita === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 1 || jogada !== 4'b0011 || db_estado !== 4'd2) begin
         n_fail++; $display("FAIL pressed_ignore pulses=%0d jogada=%b estado=%0d exp 1/0011/2", pulses, jogada, db_estado);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (jogada !== 4'd0 || jogada_valida !== 1'b0 || jogada_feita !== 1'b0 || db_estado !== 4'd0) begin
         n_fail++; $display("FAIL async_reset jogada=%b valida=%b feita=%b estado=%0d exp all 0",
                            jogada, jogada_valida, jogada_feita, db_estado);
      end
      botoes = 4'b0000;
      step();
      reset = 1'b1;
      repeat (4) step();
      n_checks++; if (jogada_feita !== 1'b0 || db_estado !== 4'd0) begin
         n_fail++; $display("FAIL post_reset feita=%b estado=%0d exp 0/0", jogada_feita, db_estado);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_press_bounce();
      test_release_bounce();
      test_habilita();
      test_multi_key_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
